ula_arbiter: RTL and testbench
==============================

// Module: ula_arbiter
// PURPOSE
//   Shares one ula + comparator pair among NUM_REQ requesters; each request carries a, b and ALUControl.
//   Requesters are granted in round-robin order; operands are registered, the ALU result is captured,
//   and one response is returned per request with result, flags {n,z,c,v} and cmp {hs,ls,hi,lo}.
//   Sits between the instruction-sequencing logic and the single shared ula instance.
// PARAMETERS
//   ULA_BITS  4  datapath width; passed to ula and comparator
//   NUM_REQ   2  number of requesters, 2..4; ID_W = $clog2(NUM_REQ)
// PORTS
//   clk         in   1                  clock; all state changes on posedge
//   reset       in   1                  synchronous, active-high reset
//   req_valid   in   NUM_REQ            request pending, one bit per requester
//   req_ready   out  NUM_REQ            one-hot grant/accept; at most one bit high
//   req_a       in   NUM_REQ*ULA_BITS   operand a, requester i in slice i
//   req_b       in   NUM_REQ*ULA_BITS   operand b, same slicing
//   req_op      in   NUM_REQ*3          ALUControl, same slicing
//   rsp_valid   out  1                  response held until accepted
//   rsp_ready   in   1                  response consumer ready
//   rsp_id      out  ID_W               index of the requester being answered
//   rsp_result  out  ULA_BITS           ula result
//   rsp_flags   out  4                  {negative, zero, carry, overflow}
//   rsp_cmp     out  4                  {hs, ls, hi, lo} from comparator
//   rsp_err     out  1                  unsupported ALUControl code
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0,
//     rsp_cmp=0, rsp_err=0, req_ready=0. A reset in any state drops the in-flight op; no response is issued.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     req_ready[winner]=1 combinationally; req_ready=0 if no valid.
//     On handshake: latch a, b, op, id into operand regs; go to EXEC.
//   EXEC: req_ready=0; ula is driven by the operand regs. Capture result, flags and cmp into rsp regs;
//     rsp_err = op not in {000 add, 001 sub, 010 and, 011 or, 101 slt}.
//     If rsp_err: result, flags and cmp are forced to 0. Go to RESP.
//   RESP: rsp_valid=1; req_ready=0; all rsp_* stable until rsp_ready.
//     On rsp_valid&rsp_ready: rsp_valid<=0; rr_ptr<=(rsp_id+1) mod NUM_REQ; go to IDLE.
//   Latency: accept at edge T -> rsp_valid high from cycle T+2. Max throughput is 1 op per 3 cycles.
//     No new accept in the same cycle as the response handshake.
//   req_valid is not required to stay high before grant; a dropped request is simply not served.
//   Arithmetic: sub is a + ~b + 1; carry=1 means no borrow. overflow applies to add/sub only, else 0.
//     Comparator (unsigned, after sub): hs=c, lo=~c, hi=c&~z, ls=~c|z.
//   rr_ptr wraps from NUM_REQ-1 to 0. Starvation-free: each waiting requester is served within NUM_REQ grants.
// STRUCTURE
//   Package ula_pkg holds: alu_op_t enum (ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLT=3'b101),
//     arb_state_t {IDLE, EXEC, RESP}, flags_t packed struct {n,z,c,v}, cmp_t packed struct {hs,ls,hi,lo}.
//   Sub-module rr_arbiter #(NUM_REQ): inputs req_valid, rr_ptr; output one-hot grant + encoded index.
//   Instantiates existing ula #(ULA_BITS) and comparator #(ULA_BITS) unchanged.
// TESTING
//   1 add: req0 a=0111 b=0001 op=000 -> rsp_id=0, result=1000, n=1 z=0 c=0 v=1, rsp_valid at T+2.
//   2 sub equal: req1 a=0011 b=0011 op=001 -> result=0000, z=1 c=1, cmp hs=1 ls=1 hi=0 lo=0.
//   3 round-robin: req_valid=11 held for 4 ops, rsp_ready=1 -> grants 0,1,0,1; rsp_id matches each grant.
//   4 backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable; req_ready=00 throughout.
//   5 illegal op: op=111 a=1111 b=0001 -> rsp_err=1, result=0000, flags=0000, cmp=0000; next op is normal.
//   6 reset in EXEC: reset 1 cycle -> rsp_valid stays 0, rr_ptr=0; next grant goes to req0 when both valid.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types and helpers for the ula arbiter slice.
package ula_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic hs;
    logic ls;
    logic hi;
    logic lo;
  } cmp_t;

  // True for the ALUControl codes the ula implements.
  function automatic logic op_supported(logic [2:0] op);
    case (op)
      ADD, SUB, AND, OR, SLT: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude compare of a against b, derived from a - b.
module comparator
  import ula_pkg::*;
#(
  parameter int unsigned ULA_BITS = 4
) (
  input  logic [ULA_BITS-1:0] a_i,
  input  logic [ULA_BITS-1:0] b_i,
  output logic [3:0]          cmp_o
);

  localparam int unsigned SUM_W = ULA_BITS + 1;

  logic [SUM_W-1:0] diff;
  logic             c;
  logic             z;
  cmp_t             cmp;

  // Carry out of a + ~b + 1 means a >= b.
  always_comb begin
    diff   = {1'b0, a_i} + {1'b0, ~b_i} + SUM_W'(1);
    c      = diff[ULA_BITS];
    z      = ~|diff[ULA_BITS-1:0];
    cmp.hs = c;
    cmp.lo = ~c;
    cmp.hi = c & ~z;
    cmp.ls = ~c | z;
  end

  assign cmp_o = cmp;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first valid requester scanning upward from rr_ptr.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic        found;
  logic        req_bit;
  int unsigned j;

  // Scan NUM_REQ positions starting at the pointer; first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    req_bit     = 1'b0;
    j           = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j       = (32'(rr_ptr_i) + k) % NUM_REQ;
      req_bit = 1'(req_valid_i >> j);
      if (!found && req_bit) begin
        found       = 1'b1;
        grant_o     = NUM_REQ'(1) << j;
        grant_idx_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/ula.sv
// Small ALU: add, sub, and, or, signed set-less-than with {n,z,c,v} flags.
module ula
  import ula_pkg::*;
#(
  parameter int unsigned ULA_BITS = 4
) (
  input  logic [ULA_BITS-1:0] a_i,
  input  logic [ULA_BITS-1:0] b_i,
  input  logic [2:0]          alu_control_i,
  output logic [ULA_BITS-1:0] result_o,
  output logic [3:0]          flags_o
);

  localparam int unsigned SUM_W = ULA_BITS + 1;
  localparam int unsigned MSB   = ULA_BITS - 1;

  logic [ULA_BITS-1:0] b_eff;
  logic [SUM_W-1:0]    sum;
  logic                ovf;
  logic                addsub;
  logic [ULA_BITS-1:0] res;
  flags_t              fl;

  // Shared adder (bit0 of ALUControl selects a + ~b + 1), result mux and flags.
  always_comb begin
    b_eff  = alu_control_i[0] ? ~b_i : b_i;
    sum    = {1'b0, a_i} + {1'b0, b_eff} + SUM_W'(alu_control_i[0]);
    ovf    = ~(a_i[MSB] ^ b_eff[MSB]) & (a_i[MSB] ^ sum[MSB]);
    addsub = (alu_control_i == ADD) || (alu_control_i == SUB);
    case (alu_control_i)
      ADD, SUB: res = sum[ULA_BITS-1:0];
      AND:      res = a_i & b_i;
      OR:       res = a_i | b_i;
      SLT:      res = ULA_BITS'(sum[MSB] ^ ovf);
      default:  res = '0;
    endcase
    fl.n = res[MSB];
    fl.z = ~|res;
    fl.c = addsub & sum[ULA_BITS];
    fl.v = addsub & ovf;
  end

  assign result_o = res;
  assign flags_o  = fl;

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ula + comparator among NUM_REQ requesters, one response per request.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter  int unsigned ULA_BITS = 4,
  parameter  int unsigned NUM_REQ  = 2,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*ULA_BITS-1:0] req_a,
  input  logic [NUM_REQ*ULA_BITS-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]    req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [ULA_BITS-1:0]     rsp_result,
  output logic [3:0]              rsp_flags,
  output logic [3:0]              rsp_cmp,
  output logic                    rsp_err
);

  arb_state_t          state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ULA_BITS-1:0] op_a_q;
  logic [ULA_BITS-1:0] op_b_q;
  logic [2:0]          op_q;
  logic [ID_W-1:0]     id_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [ULA_BITS-1:0] rsp_result_q;
  logic [3:0]          rsp_flags_q;
  logic [3:0]          rsp_cmp_q;
  logic                rsp_err_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [ULA_BITS-1:0] sel_a;
  logic [ULA_BITS-1:0] sel_b;
  logic [2:0]          sel_op;
  logic [ULA_BITS-1:0] ula_result;
  logic [3:0]          ula_flags;
  logic [3:0]          cmp_out;
  logic                op_err;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  ula #(
    .ULA_BITS (ULA_BITS)
  ) u_ula (
    .a_i           (op_a_q),
    .b_i           (op_b_q),
    .alu_control_i (op_q),
    .result_o      (ula_result),
    .flags_o       (ula_flags)
  );

  comparator #(
    .ULA_BITS (ULA_BITS)
  ) u_cmp (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .cmp_o (cmp_out)
  );

  // Operand slice of the current winner.
  assign sel_a  = ULA_BITS'(req_a >> (32'(grant_idx) * ULA_BITS));
  assign sel_b  = ULA_BITS'(req_b >> (32'(grant_idx) * ULA_BITS));
  assign sel_op = 3'(req_op >> (32'(grant_idx) * 3));
  assign op_err = ~op_supported(op_q);

  // Grant is only offered while idle and out of reset.
  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;

  // Accept -> execute -> respond sequencer with registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_cmp_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            op_q    <= sel_op;
            id_q    <= grant_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_id_q     <= id_q;
          rsp_err_q    <= op_err;
          rsp_result_q <= op_err ? '0 : ula_result;
          rsp_flags_q  <= op_err ? '0 : ula_flags;
          rsp_cmp_q    <= op_err ? '0 : cmp_out;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= (32'(rsp_id_q) == NUM_REQ - 1) ? '0 : rsp_id_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_cmp    = rsp_cmp_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized + directed bench for ula_arbiter with a queue-based scoreboard.
module tb_ula_arbiter;

  localparam int W    = 4;
  localparam int N    = 2;
  localparam int ID_W = $clog2(N);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [W-1:0]    result;
    logic [3:0]      flags;
    logic [3:0]      cmp;
    logic            err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*3-1:0]   req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [W-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic [3:0]       rsp_cmp;
  logic             rsp_err;

  logic [W-1:0]     a_arr  [N];
  logic [W-1:0]     b_arr  [N];
  logic [2:0]       op_arr [N];

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   ptr    = 0;
  bit   busy   = 1'b0;
  int   cyc    = 0;
  int   vcyc   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*W +: W]  = a_arr[g];
    assign req_b[g*W +: W]  = b_arr[g];
    assign req_op[g*3 +: 3] = op_arr[g];
  end

  ula_arbiter #(
    .ULA_BITS (W),
    .NUM_REQ  (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_cmp    (rsp_cmp),
    .rsp_err    (rsp_err)
  );

  function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(int id, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    exp_t m;
    int ua, ub, sa, sb2, r, lim_hi, lim_lo;
    bit c, v, err;
    ua = int'(a); ub = int'(b);
    sa  = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb2 = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    lim_hi = 2**(W-1) - 1;
    lim_lo = -(2**(W-1));
    r = 0; c = 0; v = 0; err = 0;
    case (op)
      3'd0: begin
        r = (ua + ub) % (2**W);
        c = (ua + ub) >= 2**W;
        v = (sa + sb2 > lim_hi) || (sa + sb2 < lim_lo);
      end
      3'd1: begin
        r = (ua - ub + 2**W) % (2**W);
        c = ua >= ub;
        v = (sa - sb2 > lim_hi) || (sa - sb2 < lim_lo);
      end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd5: r = (sa < sb2) ? 1 : 0;
      default: err = 1;
    endcase
    m.id  = ID_W'(id);
    m.err = err;
    if (err) begin
      m.result = '0; m.flags = '0; m.cmp = '0;
    end else begin
      m.result = W'(r);
      m.flags  = {r >= 2**(W-1), r == 0, c, v};
      m.cmp    = {ua >= ub, ua <= ub, ua > ub, ua < ub};
    end
    return m;
  endfunction

  function automatic logic [N-1:0] winner(logic [N-1:0] rv, int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (rv[ID_W'(j)]) return N'(1) << j;
    end
    return '0;
  endfunction

  // Monitor: grant prediction, accept capture, response compare/pop.
  always @(negedge clk) begin
    logic [N-1:0] er;
    bit           exp_rv;
    int           wid;
    cyc++;
    if (reset) begin
      chk(req_ready == '0, "reset_ready", 32'(req_ready), 0);
      sb.delete();
      ptr  = 0;
      busy = 1'b0;
    end else begin
      er = busy ? '0 : winner(req_valid, ptr);
      chk(req_ready == er, "grant", 32'(req_ready), 32'(er));
      exp_rv = (sb.size() > 0) && (cyc >= vcyc);
      chk(rsp_valid == exp_rv, "rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (rsp_valid && sb.size() > 0) begin
        chk(rsp_id == sb[0].id, "rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk(rsp_result == sb[0].result, "rsp_result", 32'(rsp_result), 32'(sb[0].result));
        chk(rsp_flags == sb[0].flags, "rsp_flags", 32'(rsp_flags), 32'(sb[0].flags));
        chk(rsp_cmp == sb[0].cmp, "rsp_cmp", 32'(rsp_cmp), 32'(sb[0].cmp));
        chk(rsp_err == sb[0].err, "rsp_err", 32'(rsp_err), 32'(sb[0].err));
        if (rsp_ready) begin
          ptr  = (int'(sb[0].id) + 1) % N;
          void'(sb.pop_front());
          busy = 1'b0;
        end
      end
      if (er != '0) begin
        wid = 0;
        for (int i = 0; i < N; i++) if (er[ID_W'(i)]) wid = i;
        sb.push_back(model(wid, a_arr[ID_W'(wid)], b_arr[ID_W'(wid)], op_arr[ID_W'(wid)]));
        busy = 1'b1;
        vcyc = cyc + 2;
      end
    end
  end

  task automatic issue(int id, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    int t;
    @(posedge clk); #1;
    a_arr[ID_W'(id)]     = a;
    b_arr[ID_W'(id)]     = b;
    op_arr[ID_W'(id)]    = op;
    req_valid[ID_W'(id)] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[ID_W'(id)] && t < 30);
    chk(req_ready[ID_W'(id)], "issue_timeout", 32'(req_ready), 32'(id));
    @(posedge clk); #1;
    req_valid[ID_W'(id)] = 1'b0;
  endtask

  task automatic wait_rsp(int id, logic [W-1:0] res, logic [3:0] fl, logic [3:0] cm, logic er);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 30);
    chk(rsp_valid, "rsp_timeout", 32'(rsp_valid), 1);
    chk(rsp_id == ID_W'(id), "dir_id", 32'(rsp_id), 32'(id));
    chk(rsp_result == res, "dir_result", 32'(rsp_result), 32'(res));
    chk(rsp_flags == fl, "dir_flags", 32'(rsp_flags), 32'(fl));
    chk(rsp_cmp == cm, "dir_cmp", 32'(rsp_cmp), 32'(cm));
    chk(rsp_err == er, "dir_err", 32'(rsp_err), 32'(er));
    @(posedge clk); #1;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int t;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; b_arr[i] = '0; op_arr[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk(rsp_valid == 1'b0, "rst_valid", 32'(rsp_valid), 0);
    chk(rsp_id == '0, "rst_id", 32'(rsp_id), 0);
    chk(rsp_result == '0, "rst_result", 32'(rsp_result), 0);
    chk(rsp_flags == '0, "rst_flags", 32'(rsp_flags), 0);
    chk(rsp_cmp == '0, "rst_cmp", 32'(rsp_cmp), 0);
    chk(rsp_err == 1'b0, "rst_err", 32'(rsp_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // add with signed overflow
    issue(0, 4'b0111, 4'b0001, 3'b000);
    wait_rsp(0, 4'b1000, 4'b1001, 4'b1010, 1'b0);
    // sub of equal operands
    issue(1, 4'b0011, 4'b0011, 3'b001);
    wait_rsp(1, 4'b0000, 4'b0110, 4'b1100, 1'b0);

    // round-robin with both requesters held valid
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = W'($urandom); b_arr[i] = W'($urandom); op_arr[i] = 3'($urandom_range(0, 3));
    end
    req_valid = '1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(rsp_valid && rsp_ready) && t < 30);
      chk(rsp_valid && rsp_ready, "rr_timeout", 32'(rsp_valid), 1);
      chk(rsp_id == ID_W'(i % 2), "rr_order", 32'(rsp_id), 32'(i % 2));
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (2) @(posedge clk);

    // response backpressure
    rsp_ready = 1'b0;
    issue(0, 4'b0101, 4'b1001, 3'b010);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 30);
    chk(rsp_valid, "bp_timeout", 32'(rsp_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk(req_ready == '0, "bp_ready", 32'(req_ready), 0);
      chk(rsp_valid == 1'b1, "bp_valid", 32'(rsp_valid), 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    // illegal op then a normal one
    issue(1, 4'b1111, 4'b0001, 3'b111);
    wait_rsp(1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    issue(0, 4'b0010, 4'b0001, 3'b001);
    wait_rsp(0, 4'b0001, 4'b0010, 4'b1010, 1'b0);

    // reset while executing drops the operation
    issue(1, 4'b0100, 4'b0011, 3'b000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk(rsp_valid == 1'b0, "rst_exec_valid", 32'(rsp_valid), 0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk(req_ready == N'(1), "rst_rr", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);

    // random traffic
    repeat (300) begin
      @(posedge clk); #1;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        a_arr[i]  = W'($urandom);
        b_arr[i]  = W'($urandom);
        op_arr[i] = 3'($urandom_range(0, 7));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk(sb.size() == 0, "drain", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
